// File: rtl/eka_pkg.sv
// Shared opcodes, ALU operation codes and the decoded control bundle
// for the Eka RV32I decode stage.
package eka_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        link;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_to_reg;
    logic        r1_zero;
    logic        r1_pc;
    logic        alu_src;
    logic        reg_wr;
    logic [3:0]  alu_ctrl;
    logic        illegal;
  } dec_ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/eka_decode_comb.sv
// Pure combinational RV32I decoder: raw instruction to control bundle.
// Register fields are always extracted; controls not used by an opcode stay 0.
module eka_decode_comb
  import eka_pkg::*;
#(
  parameter bit ENABLE_JUMPS = 1'b1
) (
  input  logic [31:0] instr,
  output dec_ctrl_t   ctrl
);

  logic [2:0] funct3;
  assign funct3 = instr[14:12];

  always_comb begin
    ctrl        = '0;
    ctrl.rs1    = instr[19:15];
    ctrl.rs2    = instr[24:20];
    ctrl.rd     = instr[11:7];
    ctrl.funct3 = funct3;
    case (instr[6:0])
      OP_R: begin
        ctrl.alu_ctrl = {instr[30], funct3};
        ctrl.reg_wr   = 1'b1;
      end
      OP_IMM: begin
        ctrl.alu_src  = 1'b1;
        ctrl.reg_wr   = 1'b1;
        ctrl.imm      = imm_i(instr);
        // instr[30] is an opcode bit only for the shift-right pair
        ctrl.alu_ctrl = (funct3 == 3'b101) ? {instr[30], funct3} : {1'b0, funct3};
      end
      OP_LOAD: begin
        ctrl.mem_rd     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_wr     = 1'b1;
        ctrl.alu_ctrl   = ALU_ADD;
        ctrl.imm        = imm_i(instr);
      end
      OP_STORE: begin
        ctrl.mem_wr   = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_ctrl = ALU_ADD;
        ctrl.imm      = imm_s(instr);
      end
      OP_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.imm      = imm_b(instr);
      end
      OP_LUI: begin
        ctrl.r1_zero  = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.reg_wr   = 1'b1;
        ctrl.alu_ctrl = ALU_ADD;
        ctrl.imm      = imm_u(instr);
      end
      OP_AUIPC: begin
        ctrl.r1_pc    = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.reg_wr   = 1'b1;
        ctrl.alu_ctrl = ALU_ADD;
        ctrl.imm      = imm_u(instr);
      end
      OP_JAL: begin
        if (ENABLE_JUMPS) begin
          ctrl.jump     = 1'b1;
          ctrl.link     = 1'b1;
          ctrl.r1_pc    = 1'b1;
          ctrl.alu_src  = 1'b1;
          ctrl.reg_wr   = 1'b1;
          ctrl.alu_ctrl = ALU_ADD;
          ctrl.imm      = imm_j(instr);
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (ENABLE_JUMPS) begin
          ctrl.jump     = 1'b1;
          ctrl.jalr     = 1'b1;
          ctrl.link     = 1'b1;
          ctrl.alu_src  = 1'b1;
          ctrl.reg_wr   = 1'b1;
          ctrl.alu_ctrl = ALU_ADD;
          ctrl.imm      = imm_i(instr);
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/eka_decode_stage.sv
// Registered decode stage: decodes at capture and presents results from a
// two-entry (output + skid) buffer with valid/ready flow control and flush.
module eka_decode_stage
  import eka_pkg::*;
#(
  parameter int PC_WIDTH     = 32,
  parameter bit ENABLE_JUMPS = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [2:0]          out_funct3,
  output logic [31:0]         out_imm,
  output logic                out_branch,
  output logic                out_jump,
  output logic                out_jalr,
  output logic                out_link,
  output logic                out_mem_rd,
  output logic                out_mem_wr,
  output logic                out_mem_to_reg,
  output logic                out_r1_zero,
  output logic                out_r1_pc,
  output logic                out_alu_src,
  output logic                out_reg_wr,
  output logic [3:0]          out_alu_ctrl,
  output logic                out_illegal
);

  dec_ctrl_t dec_ctrl;

  eka_decode_comb #(
    .ENABLE_JUMPS(ENABLE_JUMPS)
  ) u_decode (
    .instr(in_instr),
    .ctrl (dec_ctrl)
  );

  buf_state_e          state_reg, state_next;
  logic                in_ready_reg;
  logic                out_valid_int;
  dec_ctrl_t           out_ctrl_reg, skid_ctrl_reg;
  logic [PC_WIDTH-1:0] out_pc_reg, skid_pc_reg;
  logic                accept, consume;

  assign accept  = in_valid & in_ready_reg;
  assign consume = out_valid_int & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != ST_FULL);
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: if (accept) state_next = ST_ONE;
        ST_ONE: begin
          if (accept && !consume)      state_next = ST_FULL;
          else if (!accept && consume) state_next = ST_EMPTY;
        end
        ST_FULL:  if (consume) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid_int = (state_reg != ST_EMPTY);
  end

  // Entries move only on handshakes, so the output slot holds still while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_ctrl_reg  <= '0;
      out_pc_reg    <= '0;
      skid_ctrl_reg <= '0;
      skid_pc_reg   <= '0;
    end else if (!flush) begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            out_ctrl_reg <= dec_ctrl;
            out_pc_reg   <= in_pc;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            out_ctrl_reg <= dec_ctrl;
            out_pc_reg   <= in_pc;
          end else if (accept) begin
            skid_ctrl_reg <= dec_ctrl;
            skid_pc_reg   <= in_pc;
          end
        end
        ST_FULL: begin
          if (consume) begin
            out_ctrl_reg <= skid_ctrl_reg;
            out_pc_reg   <= skid_pc_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready       = in_ready_reg;
  assign out_valid      = out_valid_int;
  assign out_pc         = out_pc_reg;
  assign out_rs1        = out_ctrl_reg.rs1;
  assign out_rs2        = out_ctrl_reg.rs2;
  assign out_rd         = out_ctrl_reg.rd;
  assign out_funct3     = out_ctrl_reg.funct3;
  assign out_imm        = out_ctrl_reg.imm;
  assign out_branch     = out_ctrl_reg.branch;
  assign out_jump       = out_ctrl_reg.jump;
  assign out_jalr       = out_ctrl_reg.jalr;
  assign out_link       = out_ctrl_reg.link;
  assign out_mem_rd     = out_ctrl_reg.mem_rd;
  assign out_mem_wr     = out_ctrl_reg.mem_wr;
  assign out_mem_to_reg = out_ctrl_reg.mem_to_reg;
  assign out_r1_zero    = out_ctrl_reg.r1_zero;
  assign out_r1_pc      = out_ctrl_reg.r1_pc;
  assign out_alu_src    = out_ctrl_reg.alu_src;
  assign out_reg_wr     = out_ctrl_reg.reg_wr;
  assign out_alu_ctrl   = out_ctrl_reg.alu_ctrl;
  assign out_illegal    = out_ctrl_reg.illegal;

endmodule

// File: tb/tb_eka_decode_stage.sv
// Scoreboard bench: two stage instances (jumps enabled / disabled) share
// stimulus; expected bundles are queued at accept and checked by a monitor.
module tb_eka_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;
  logic [3:0]  out_alu_ctrl;
  logic        out_branch, out_jump, out_jalr, out_link, out_mem_rd, out_mem_wr;
  logic        out_mem_to_reg, out_r1_zero, out_r1_pc, out_alu_src, out_reg_wr, out_illegal;

  logic        in_ready_n, out_valid_n;
  logic [31:0] out_pc_n, out_imm_n;
  logic [4:0]  out_rs1_n, out_rs2_n, out_rd_n;
  logic [2:0]  out_funct3_n;
  logic [3:0]  out_alu_ctrl_n;
  logic        out_branch_n, out_jump_n, out_jalr_n, out_link_n, out_mem_rd_n, out_mem_wr_n;
  logic        out_mem_to_reg_n, out_r1_zero_n, out_r1_pc_n, out_alu_src_n, out_reg_wr_n, out_illegal_n;

  always #5 clk = ~clk;

  eka_decode_stage #(.PC_WIDTH(32), .ENABLE_JUMPS(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_imm(out_imm), .out_branch(out_branch), .out_jump(out_jump), .out_jalr(out_jalr),
    .out_link(out_link), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_mem_to_reg(out_mem_to_reg), .out_r1_zero(out_r1_zero), .out_r1_pc(out_r1_pc),
    .out_alu_src(out_alu_src), .out_reg_wr(out_reg_wr), .out_alu_ctrl(out_alu_ctrl),
    .out_illegal(out_illegal)
  );

  eka_decode_stage #(.PC_WIDTH(32), .ENABLE_JUMPS(1'b0)) dut_nj (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_pc(out_pc_n),
    .out_rs1(out_rs1_n), .out_rs2(out_rs2_n), .out_rd(out_rd_n), .out_funct3(out_funct3_n),
    .out_imm(out_imm_n), .out_branch(out_branch_n), .out_jump(out_jump_n), .out_jalr(out_jalr_n),
    .out_link(out_link_n), .out_mem_rd(out_mem_rd_n), .out_mem_wr(out_mem_wr_n),
    .out_mem_to_reg(out_mem_to_reg_n), .out_r1_zero(out_r1_zero_n), .out_r1_pc(out_r1_pc_n),
    .out_alu_src(out_alu_src_n), .out_reg_wr(out_reg_wr_n), .out_alu_ctrl(out_alu_ctrl_n),
    .out_illegal(out_illegal_n)
  );

  logic [97:0] act_j, act_n;
  assign act_j = {out_pc, out_rs1, out_rs2, out_rd, out_funct3, out_imm,
                  out_branch, out_jump, out_jalr, out_link, out_mem_rd, out_mem_wr,
                  out_mem_to_reg, out_r1_zero, out_r1_pc, out_alu_src, out_reg_wr,
                  out_alu_ctrl, out_illegal};
  assign act_n = {out_pc_n, out_rs1_n, out_rs2_n, out_rd_n, out_funct3_n, out_imm_n,
                  out_branch_n, out_jump_n, out_jalr_n, out_link_n, out_mem_rd_n, out_mem_wr_n,
                  out_mem_to_reg_n, out_r1_zero_n, out_r1_pc_n, out_alu_src_n, out_reg_wr_n,
                  out_alu_ctrl_n, out_illegal_n};

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [65:0] exp_j;
    logic [65:0] exp_n;
  } item_t;

  item_t q[$];
  int    tests = 0;
  int    fails = 0;
  int    pushed_now = 0;
  bit    started = 1'b0;

  // Reference decoder, written straight from the opcode table.
  // Result layout: {rs1,rs2,rd,funct3,imm,branch,jump,jalr,link,mem_rd,mem_wr,
  //                 mem_to_reg,r1_zero,r1_pc,alu_src,reg_wr,alu_ctrl,illegal}
  function automatic logic [65:0] model(input logic [31:0] i, input bit ej);
    logic [31:0] immi, imms, immb, immu, immj, imm;
    logic [3:0]  alu;
    bit br, jp, jr, lk, mr, mw, mtr, rz, rp, as, rw, ill;
    immi = 32'($signed(i) >>> 20);
    imms = {{20{i[31]}}, i[31:25], i[11:7]};
    immb = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    immu = {i[31:12], 12'h000};
    immj = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    imm = '0; alu = 4'b0000;
    {br, jp, jr, lk, mr, mw, mtr, rz, rp, as, rw, ill} = '0;
    case (i[6:0])
      7'h33: begin alu = {i[30], i[14:12]}; rw = 1; end
      7'h13: begin
        as = 1; rw = 1; imm = immi;
        alu = (i[14:12] == 3'd5) ? {i[30], 3'd5} : {1'b0, i[14:12]};
      end
      7'h03: begin mr = 1; mtr = 1; as = 1; rw = 1; imm = immi; end
      7'h23: begin mw = 1; as = 1; imm = imms; end
      7'h63: begin br = 1; alu = 4'b1000; imm = immb; end
      7'h37: begin rz = 1; as = 1; rw = 1; imm = immu; end
      7'h17: begin rp = 1; as = 1; rw = 1; imm = immu; end
      7'h6F: if (ej) begin jp = 1; lk = 1; rp = 1; as = 1; rw = 1; imm = immj; end
             else ill = 1;
      7'h67: if (ej) begin jp = 1; jr = 1; lk = 1; as = 1; rw = 1; imm = immi; end
             else ill = 1;
      default: ill = 1;
    endcase
    return {i[19:15], i[24:20], i[11:7], i[14:12], imm,
            br, jp, jr, lk, mr, mw, mtr, rz, rp, as, rw, alu, ill};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ordy, input bit fl, input bit rst, output bit acc);
    item_t it;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; reset = rst;
    #1;
    acc = v && (in_ready === 1'b1) && !fl && !rst;
    if (acc) begin
      it.pc = pc; it.instr = ins; it.exp_j = model(ins, 1'b1); it.exp_n = model(ins, 1'b0);
      q.push_back(it);
      pushed_now = 1;
    end else begin
      pushed_now = 0;
    end
  endtask

  // Monitor: occupancy-based flow-control checks and in-order entry checks
  initial begin : monitor
    int  occ;
    bit  zero_chk;
    item_t h;
    zero_chk = 1'b0;
    wait (started);
    forever begin
      @(negedge clk);
      #2;
      occ = q.size() - pushed_now;
      chk("out_valid", 128'(out_valid), 128'(occ > 0));
      chk("in_ready", 128'(in_ready), 128'(occ < 2));
      chk("out_valid_nj", 128'(out_valid_n), 128'(occ > 0));
      chk("in_ready_nj", 128'(in_ready_n), 128'(occ < 2));
      if (zero_chk) begin
        chk("reset_zero", 128'(act_j), 128'(0));
        chk("reset_zero_nj", 128'(act_n), 128'(0));
        zero_chk = 1'b0;
      end
      if (occ > 0) begin
        h = q[0];
        chk("entry", 128'(act_j), 128'({h.pc, h.exp_j}));
        chk("entry_nj", 128'(act_n), 128'({h.pc, h.exp_n}));
      end
      if (reset || flush) begin
        q.delete();
        zero_chk = reset;
      end else if (occ > 0 && out_ready) begin
        $display("[TB] consumed pc=%08h instr=%08h", h.pc, h.instr);
        void'(q.pop_front());
      end
    end
  end

  initial begin : timeout
    #400000;
    $display("FAIL timeout: simulation did not finish, got no end, expected finish");
    $fatal(1, "timeout");
  end

  logic [31:0] dir_list [12] = '{
    32'h00500093, 32'h402081B3, 32'h4030D093, 32'hFF9FF0EF,
    32'hFFFFFFFF, 32'h00812283, 32'h00512623, 32'hFE208EE3,
    32'h123453B7, 32'h00001417, 32'h004100E7, 32'h00000000
  };
  logic [6:0] op_list [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

  task automatic drain(input string name);
    bit a;
    for (int c = 0; c < 20 && q.size() != 0; c++) step(0, '0, '0, 1, 0, 0, a);
    chk(name, 128'(q.size()), 128'(0));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = op_list[$urandom_range(0, 8)];
    return r;
  endfunction

  initial begin : driver
    bit acc;
    int idx;
    logic [31:0] pc;
    pc = 32'h100;
    step(0, '0, '0, 0, 0, 1, acc);
    step(0, '0, '0, 0, 0, 1, acc);
    started = 1'b1;
    step(0, '0, '0, 0, 0, 1, acc);

    // Directed decode vectors, one per cycle with full throughput
    for (int k = 0; k < 12; k++) begin
      idx = 0;
      for (int c = 0; c < 10 && idx == 0; c++) begin
        step(1, dir_list[k], pc, 1, 0, 0, acc);
        if (acc) idx = 1;
      end
      chk("directed_accept", 128'(idx), 128'(1));
      pc += 4;
    end
    drain("drain_directed");

    // Four instructions with execute stalled for the first three cycles
    idx = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      step(1, dir_list[idx], pc, c >= 3, 0, 0, acc);
      if (acc) begin idx++; pc += 4; end
    end
    chk("stream_accepted", 128'(idx), 128'(4));
    drain("drain_stream");

    // Fill to FULL, then flush while fetch offers another instruction
    idx = 0;
    for (int c = 0; c < 10 && in_ready !== 1'b0; c++) begin
      step(1, rand_instr(), pc, 0, 0, 0, acc);
      pc += 4;
    end
    step(1, 32'h00700113, pc, 0, 1, 0, acc);
    pc += 4;
    step(0, '0, '0, 1, 0, 0, acc);
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));

    // Flush from a single entry while an accept would otherwise happen
    step(1, 32'h00100093, pc, 0, 0, 0, acc);
    pc += 4;
    step(1, 32'h00200113, pc, 0, 1, 0, acc);
    pc += 4;
    drain("drain_flush");

    // Randomised traffic with occasional flush and one mid-stream reset
    for (int c = 0; c < 500; c++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), pc,
           $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, c == 250, acc);
      if (acc) pc += 4;
    end
    drain("drain_random");
    step(0, '0, '0, 1, 0, 0, acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eka_decode_stage.md
# eka_decode_stage

Registered, flow-controlled instruction decode stage for the Eka RV32I core. It sits between the fetch stage and the execute stage. It accepts one fetched instruction plus its PC per cycle over a valid/ready handshake, decodes it into the full control bundle, and presents the result from a two-entry output buffer. Compared with the purely combinational decoder, it adds JAL/JALR decoding, illegal-opcode detection, fixed values for every output on every opcode, backpressure and flush.

## Interface
- `PC_WIDTH`, 32: width of the PC carried alongside the instruction.
- `ENABLE_JUMPS`, 1: when 0, JAL/JALR decode as illegal.
- `clk` in 1: single clock for the block.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: fetch offers an instruction.
- `in_ready` out 1: stage can accept; registered.
- `in_instr` in 32: raw instruction.
- `in_pc` in PC_WIDTH: PC of `in_instr`.
- `flush` in 1: discard all buffered entries.
- `out_valid` out 1: decoded entry present.
- `out_ready` in 1: execute consumes the entry.
- `out_pc` out PC_WIDTH: PC of the decoded instruction.
- `out_rs1`, `out_rs2`, `out_rd` out 5 each: register fields `[19:15]`, `[24:20]`, `[11:7]`.
- `out_funct3` out 3: `[14:12]`.
- `out_imm` out 32: sign-extended immediate.
- `out_branch`, `out_jump`, `out_jalr`, `out_link` out 1 each: control-flow flags.
- `out_mem_rd`, `out_mem_wr`, `out_mem_to_reg` out 1 each: memory controls.
- `out_r1_zero`, `out_r1_pc`, `out_alu_src`, `out_reg_wr` out 1 each: operand and writeback controls.
- `out_alu_ctrl` out 4: ALU operation code.
- `out_illegal` out 1: unrecognised opcode.

## Operation
- Decode per opcode:
  - R: `alu_ctrl={instr[30],funct3}`, `reg_wr`.
  - I-ALU: `alu_src`, `reg_wr`, I-imm. `alu_ctrl={instr[30],funct3}` when funct3=101, else `{0,funct3}`.
  - LOAD: `mem_rd`, `mem_to_reg`, `alu_src`, `reg_wr`, ADD, I-imm.
  - STORE: `mem_wr`, `alu_src`, ADD, S-imm.
  - BRANCH: `branch`, SUB (1000), B-imm.
  - LUI: `r1_zero`, `alu_src`, `reg_wr`, ADD, U-imm.
  - AUIPC: `r1_pc`, `alu_src`, `reg_wr`, ADD, U-imm.
  - JAL: `jump`, `link`, `r1_pc`, `alu_src`, `reg_wr`, ADD, J-imm `{{12{i[31]}},i[19:12],i[20],i[30:21],0}`.
  - JALR: `jump`, `jalr`, `link`, `alu_src`, `reg_wr`, ADD, I-imm.
- Any other opcode sets `illegal`=1 with all other controls, including imm, at 0.
- Every control not listed for an opcode is 0. No X values are ever driven.
- Buffer FSM:
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without consume.
  - ONE→EMPTY on consume without accept.
  - FULL→ONE on consume.
  - ONE holds on simultaneous accept and consume.
- Accept = `in_valid & in_ready`; consume = `out_valid & out_ready`.
- Decode is applied at capture. The output entry and the skid entry each hold a decoded bundle. FULL drains the skid entry into the output slot on consume.
- `in_ready` = (next state != FULL), registered.
- `flush` or `reset` → EMPTY next cycle. Any same-cycle accept is discarded.
- Ordering is strictly FIFO.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- Reset values: `in_ready`=1, `out_valid`=0, all data and control outputs 0.
- Data outputs are stable while `out_valid & !out_ready`.
- `in_ready` falls the cycle after the second un-consumed accept. It rises the cycle after a consume from FULL.
- Flush has priority over accept and consume. After a flush, `out_valid`=0 and `in_ready`=1 on the next cycle.
- Reset mid-stream behaves as flush and also zeroes the data registers.

## Structure
- `eka_pkg` holds:
  - opcode localparams;
  - ALU_CTRL constants (ADD=0000, SUB=1000, etc.);
  - packed struct `dec_ctrl_t` containing all `out_*` controls plus imm.
- Sub-module `eka_decode_comb` is a pure combinational instr→`dec_ctrl_t` function. It is instantiated once, on the input side.
- The top level holds the FSM plus two `dec_ctrl_t`/PC registers.

## Test plan
- ADDI x1,x0,5 (0x00500093), pc 0x100 → next cycle: `out_valid`=1, `imm`=5, `alu_ctrl`=0000, `alu_src`=1, `reg_wr`=1, `rd`=1, `out_pc`=0x100.
- SUB x3,x1,x2 (0x402081B3) → `alu_ctrl`=1000. SRAI x1,x1,3 (0x4030D093) → `alu_ctrl`=1101, `imm`=0x403.
- JAL x1,-8 (0xFF9FF0EF) → `jump`=`link`=`r1_pc`=`reg_wr`=1, `imm`=0xFFFFFFF8. The same instruction with `ENABLE_JUMPS`=0 → `illegal`=1, `reg_wr`=0.
- 0xFFFFFFFF → `illegal`=1, and `mem_wr`=`reg_wr`=`branch`=`jump`=0, `imm`=0.
- Stream 4 instructions with `out_ready`=0 for 3 cycles → `in_ready`=0 after 2 accepts. Release `out_ready` → all 4 emerge in order with no loss or duplication.
- FULL, then `flush` with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the flushed-cycle instruction never appears.
